// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared state encoding and helpers for the writeback trace buffer
package wb_trace_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, POST, DUMP, DONE} state_t;
  function automatic logic capturing(state_t s);
    return s == ARMED || s == POST;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: entry storage with one synchronous write port and one asynchronous read port
module trace_ram #(
  parameter int W = 69,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  // entry data carries no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: writeback trace capture with pc/timeout trigger and oldest-first dump
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH = 16,
  parameter int POST_CYCLES = 4,
  parameter int TMO_W = 16,
  parameter int FILTER_X0 = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [XLEN-1:0]            stop_pc,
  input  logic [TMO_W-1:0]           timeout,
  input  logic [XLEN-1:0]            pc_in,
  input  logic                       wb_e,
  input  logic [REG_AW-1:0]          wb_a,
  input  logic [XLEN-1:0]            wb_d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [REG_AW-1:0]          out_a,
  output logic [XLEN-1:0]            out_d,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       timed_out,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(POST_CYCLES+2);
  localparam int EW = 2*XLEN + REG_AW;
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] a;
    logic [XLEN-1:0]   d;
  } trace_entry_t;
  state_t        state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q, timed_out_q;
  logic [TMO_W-1:0] cyc_q;
  logic [PW-1:0] post_q;
  trace_entry_t  wr_ent, rd_ent;
  logic          cap, full, pc_hit, tmo_hit, xfer;
  assign wr_ent    = '{pc: pc_in, a: wb_a, d: wb_d};
  assign full      = count_q == CW'(DEPTH);
  assign cap       = capturing(state_q) && wb_e && !(FILTER_X0 != 0 && wb_a == '0);
  assign pc_hit    = pc_in >= stop_pc;
  assign tmo_hit   = timeout != '0 && cyc_q == timeout - 1'b1;
  assign out_valid = state_q == DUMP && count_q != '0;
  assign xfer      = out_valid && out_ready;
  assign {out_pc, out_a, out_d} = out_valid ? rd_ent : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign timed_out = timed_out_q;
  assign busy      = state_q == ARMED || state_q == POST || state_q == DUMP;
  assign done      = state_q == DONE;
  trace_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (cap),
    .waddr(wr_ptr_q),
    .wdata(wr_ent),
    .raddr(rd_ptr_q),
    .rdata(rd_ent)
  );
  // capture/drain bookkeeping and the capture FSM; a full buffer drops its oldest entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      timed_out_q <= 1'b0;
      cyc_q       <= '0;
      post_q      <= '0;
    end else begin
      if (cap) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (full) begin
          rd_ptr_q   <= rd_ptr_q + 1'b1;
          overflow_q <= 1'b1;
        end else count_q <= count_q + 1'b1;
      end
      if (xfer) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q  <= count_q - 1'b1;
      end
      case (state_q)
        IDLE, DONE: if (arm) begin
          state_q     <= ARMED;
          wr_ptr_q    <= '0;
          rd_ptr_q    <= '0;
          count_q     <= '0;
          overflow_q  <= 1'b0;
          timed_out_q <= 1'b0;
          cyc_q       <= '0;
        end
        ARMED: begin
          cyc_q <= cyc_q + 1'b1;
          if (pc_hit || tmo_hit) begin
            timed_out_q <= !pc_hit;
            post_q      <= '0;
            state_q     <= POST_CYCLES == 0 ? DUMP : POST;
          end
        end
        POST: begin
          post_q <= post_q + 1'b1;
          if (post_q == PW'(POST_CYCLES-1)) state_q <= DUMP;
        end
        DUMP: if (count_q == '0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed self-checking bench for wb_trace_buffer
`timescale 1ns/1ps
module tb_wb_trace_buffer;
  localparam int XLEN = 32, REG_AW = 5, DEPTH = 16, TMO_W = 16;
  logic clk = 1'b0;
  logic reset, arm, wb_e, out_ready, out_valid, overflow, timed_out, busy, done;
  logic [XLEN-1:0] stop_pc, pc_in, wb_d, out_pc, out_d;
  logic [TMO_W-1:0] timeout;
  logic [REG_AW-1:0] wb_a, out_a;
  logic [4:0] count;
  int n_chk = 0, n_fail = 0;
  logic [2*XLEN+REG_AW-1:0] exp_q[$];
  bit saw;

  typedef struct {
    logic [31:0] pc;
    logic        e;
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  cnt;
    logic        vld;
  } vec_t;
  vec_t t1[10];

  always #5 clk = ~clk;

  wb_trace_buffer #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .POST_CYCLES(4),
                    .TMO_W(TMO_W), .FILTER_X0(1)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop_pc(stop_pc), .timeout(timeout),
    .pc_in(pc_in), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_a(out_a),
    .out_d(out_d), .count(count), .overflow(overflow), .timed_out(timed_out),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_wr(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    if (a != 0) begin
      exp_q.push_back({pc, a, d});
      if (exp_q.size() > DEPTH) exp_q.delete(0);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic e, input logic [4:0] a,
                       input logic [31:0] d);
    pc_in = pc; wb_e = e; wb_a = a; wb_d = d;
    if (e) model_wr(pc, a, d);
    step();
  endtask

  task automatic do_arm(input logic [31:0] stop, input logic [15:0] tmo);
    stop_pc = stop; timeout = tmo; wb_e = 0; pc_in = 0; out_ready = 0;
    arm = 1;
    step();
    arm = 0;
    exp_q.delete();
  endtask

  task automatic chk_zero(input string name);
    chk(name, {out_valid, out_pc, out_a, out_d, count, overflow, timed_out, busy, done}, '0);
  endtask

  task automatic dump(input bit rand_ready, input string tag, output bit seen);
    logic [2*XLEN+REG_AW-1:0] held;
    bit stalled;
    stalled = 0; seen = 0; held = '0; wb_e = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk({tag, "_stable"}, {out_valid, out_pc, out_a, out_d}, {1'b1, held});
      if (out_valid) begin
        seen = 1;
        if (out_ready) begin
          if (exp_q.size() == 0) chk({tag, "_extra"}, out_valid, 0);
          else begin
            chk({tag, "_entry"}, {out_pc, out_a, out_d}, exp_q[0]);
            exp_q.delete(0);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_pc, out_a, out_d};
      step();
    end
    out_ready = 0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_vld_off"}, out_valid, 0);
    chk({tag, "_cnt0"}, count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t1[0] = '{32'd10, 1'b1, 5'd1, 32'h11, 5'd1, 1'b0};
    t1[1] = '{32'd11, 1'b1, 5'd2, 32'h22, 5'd2, 1'b0};
    t1[2] = '{32'd12, 1'b1, 5'd3, 32'h33, 5'd3, 1'b0};
    t1[3] = '{32'd13, 1'b1, 5'd4, 32'h44, 5'd4, 1'b0};
    t1[4] = '{32'd14, 1'b1, 5'd5, 32'h55, 5'd5, 1'b0};
    t1[5] = '{32'd30, 1'b0, 5'd0, 32'h0,  5'd5, 1'b0};
    t1[6] = '{32'd31, 1'b1, 5'd6, 32'h66, 5'd6, 1'b0};
    t1[7] = '{32'd32, 1'b0, 5'd0, 32'h0,  5'd6, 1'b0};
    t1[8] = '{32'd33, 1'b1, 5'd7, 32'h77, 5'd7, 1'b0};
    t1[9] = '{32'd34, 1'b0, 5'd0, 32'h0,  5'd7, 1'b1};
    reset = 1; arm = 0; wb_e = 0; pc_in = 0; wb_a = 0; wb_d = 0;
    out_ready = 0; stop_pc = 0; timeout = 0;
    step(); step();
    chk_zero("reset_state");
    reset = 0;
    step();

    do_arm(32'd30, 16'd0);
    chk("t1_busy_armed", busy, 1);
    for (int i = 0; i < 10; i++) begin
      drive(t1[i].pc, t1[i].e, t1[i].a, t1[i].d);
      chk($sformatf("t1_cnt_%0d", i), count, t1[i].cnt);
      chk($sformatf("t1_vld_%0d", i), out_valid, t1[i].vld);
    end
    dump(0, "t1", saw);
    chk("t1_no_ovf", overflow, 0);

    do_arm(32'd1000, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      arm = (i == 10);
      drive(32'd100 + 32'(i), 1, 5'(i), 32'hA000 + 32'(i));
    end
    arm = 0;
    drive(32'd1000, 0, 0, 0);
    chk("t2_cnt_full", count, 16);
    chk("t2_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    dump(0, "t2", saw);
    chk("t2_ovf_held", overflow, 1);

    do_arm(32'hFFFF_FFFF, 16'd100);
    chk("rearm_ovf_clr", overflow, 0);
    chk("rearm_cnt_clr", count, 0);
    chk("rearm_not_done", done, 0);
    drive(0, 1, 9, 32'h99);
    for (int k = 2; k <= 104; k++) begin
      drive(0, 0, 0, 0);
      if (k == 99) chk("t3_to_early", timed_out, 0);
      if (k == 100) chk("t3_to_set", timed_out, 1);
      if (k == 103) chk("t3_post_vld", out_valid, 0);
      if (k == 104) chk("t3_dump_vld", out_valid, 1);
    end
    dump(0, "t3", saw);
    chk("t3_to_held", timed_out, 1);

    do_arm(32'd50, 16'd3);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(32'd50, 0, 0, 0);
    chk("t3b_pc_wins", timed_out, 0);
    chk("t3b_busy", busy, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    dump(0, "t3b", saw);

    do_arm(32'd500, 16'd0);
    for (int i = 0; i < 10; i++) drive(32'd200 + 32'(i), 1, 5'(i + 3), 32'hC0DE_0000 + 32'(i));
    drive(32'd500, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    dump(1, "t4", saw);

    do_arm(32'd600, 16'd0);
    drive(32'd300, 1, 0, 32'hDEAD);
    drive(32'd301, 1, 7, 32'h7777);
    drive(32'd600, 0, 0, 0);
    chk("t5_filter_cnt", count, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    dump(0, "t5", saw);

    do_arm(32'd0, 16'd0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    chk("t5e_busy", busy, 1);
    chk("t5e_not_done", done, 0);
    dump(0, "t5e", saw);
    chk("t5e_never_vld", saw, 0);

    do_arm(32'hFFFF_FFFF, 16'd2);
    drive(0, 1, 3, 32'h33);
    drive(0, 0, 0, 0);
    chk("t6_to_pre", timed_out, 1);
    drive(0, 1, 4, 32'h44);
    reset = 1;
    #1;
    chk_zero("t6_rst_post");
    reset = 0;
    step();
    chk("t6_idle", {busy, done}, 0);

    do_arm(32'd40, 16'd0);
    drive(32'd10, 1, 4, 32'h44);
    drive(32'd40, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    chk("t6_dump_vld", out_valid, 1);
    reset = 1;
    #1;
    chk_zero("t6_rst_dump");
    reset = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
